// File: rtl/key_event_pkg.sv
// Shared definitions for the key event debouncer.
//   key_state_t : per-channel debounce FSM state (2-bit encoding)
//   POL_LOW     : POLARITY value for active-low keys
//   POL_HIGH    : POLARITY value for active-high keys
package key_event_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_PEND   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_PEND = 2'd3
  } key_state_t;

  localparam string POL_LOW  = "LOW";
  localparam string POL_HIGH = "HIGH";

endpackage

// File: rtl/key_event_channel.sv
// Single-channel debounce FSM with press/release/long-press event pulses.
// Optional feature: define KEY_AUTOREPEAT_EN to re-pulse press every
// REPEAT_CYCLES while the key stays held after a long press.
// Ports:
//   clk           : rising-edge clock
//   reset_n       : synchronous active-low reset
//   key           : synchronized, active-high key input
//   level         : debounced key state (1 = asserted)
//   press         : one-cycle pulse on debounced assertion (and auto-repeat)
//   release_pulse : one-cycle pulse on debounced deassertion
//   long_press    : one-cycle pulse after LONG_CYCLES of continuous hold
module key_event_channel
  import key_event_pkg::*;
#(
  parameter int TIMEOUT       = 50000,
  parameter int TIMEOUT_WIDTH = 16,
  parameter int LONG_CYCLES   = 50000000,
  parameter int LONG_WIDTH    = 26,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic long_press
);

  // The debounce counter already holds 1 on the first cycle of a pending
  // state, so the transition fires when it shows TIMEOUT-1 with the input
  // still stable: that edge is the TIMEOUT-th consecutive stable sample.
  localparam logic [TIMEOUT_WIDTH-1:0] DEB_LAST  = TIMEOUT_WIDTH'(TIMEOUT - 1);
  localparam logic [LONG_WIDTH-1:0]    HOLD_MAX  = LONG_WIDTH'(LONG_CYCLES);
  localparam logic [LONG_WIDTH-1:0]    HOLD_LAST = LONG_WIDTH'(LONG_CYCLES - 1);

  key_state_t               state;
  logic [TIMEOUT_WIDTH-1:0] deb_cnt;
  logic [LONG_WIDTH-1:0]    hold_cnt;
  logic                     hold_sat;
  logic                     hold_hit;

  assign hold_sat = (hold_cnt == HOLD_MAX);
  assign hold_hit = (hold_cnt == HOLD_LAST);

`ifdef KEY_AUTOREPEAT_EN
  localparam int            REP_W    = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES + 1) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] rep_cnt;
`endif

  // FSM and counters: all outputs registered, pulses default low each cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= ST_RELEASED;
      deb_cnt       <= '0;
      hold_cnt      <= '0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      rep_cnt       <= '0;
`endif
    end else begin
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      case (state)
        ST_RELEASED: begin
          if (key) begin
            state   <= ST_PRESS_PEND;
            deb_cnt <= TIMEOUT_WIDTH'(1);
          end
        end
        ST_PRESS_PEND: begin
          if (!key) begin
            state   <= ST_RELEASED;
            deb_cnt <= '0;
          end else if (deb_cnt >= DEB_LAST) begin
            state    <= ST_PRESSED;
            deb_cnt  <= '0;
            hold_cnt <= '0;
            level    <= 1'b1;
            press    <= 1'b1;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        ST_PRESSED: begin
          if (!hold_sat) hold_cnt <= hold_cnt + 1'b1;
          long_press <= hold_hit;
          if (!key) begin
            state   <= ST_RELEASE_PEND;
            deb_cnt <= TIMEOUT_WIDTH'(1);
`ifdef KEY_AUTOREPEAT_EN
            rep_cnt <= '0;
`endif
          end
`ifdef KEY_AUTOREPEAT_EN
          // Repeat period starts on the first cycle after the hold counter
          // saturates, i.e. right after long_press.
          else if (hold_sat) begin
            if (rep_cnt == REP_LAST) begin
              press   <= 1'b1;
              rep_cnt <= '0;
            end else begin
              rep_cnt <= rep_cnt + 1'b1;
            end
          end else begin
            rep_cnt <= '0;
          end
`endif
        end
        ST_RELEASE_PEND: begin
          if (key) begin
            state   <= ST_PRESSED;
            deb_cnt <= '0;
            if (!hold_sat) hold_cnt <= hold_cnt + 1'b1;
            long_press <= hold_hit;
          end else if (deb_cnt >= DEB_LAST) begin
            state         <= ST_RELEASED;
            deb_cnt       <= '0;
            hold_cnt      <= '0;
            level         <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
            if (!hold_sat) hold_cnt <= hold_cnt + 1'b1;
            long_press <= hold_hit;
          end
        end
        default: begin
          state   <= ST_RELEASED;
          deb_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_event_debounce.sv
// Multi-channel key debouncer: per-channel 2-flop synchronizer and polarity
// normalization, feeding one key_event_channel FSM per input bit.
// Optional feature: define KEY_AUTOREPEAT_EN for auto-repeat press pulses.
// Ports:
//   clk           : rising-edge clock
//   reset_n       : synchronous active-low reset
//   data_in       : raw asynchronous key inputs, active level set by POLARITY
//   level         : debounced key states (1 = asserted)
//   press         : one-cycle pulse per channel on assertion
//   release_pulse : one-cycle pulse per channel on deassertion
//   long_press    : one-cycle pulse per channel after LONG_CYCLES held
module key_event_debounce
  import key_event_pkg::*;
#(
  parameter int    WIDTH         = 2,
  parameter string POLARITY      = "LOW",
  parameter int    TIMEOUT       = 50000,
  parameter int    TIMEOUT_WIDTH = 16,
  parameter int    LONG_CYCLES   = 50000000,
  parameter int    LONG_WIDTH    = 26,
  parameter int    REPEAT_CYCLES = 10000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] press,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] long_press
);

  localparam bit               ACTIVE_LOW = (POLARITY == POL_LOW);
  localparam logic [WIDTH-1:0] IDLE_RAW   = ACTIVE_LOW ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  if (TIMEOUT < 1 || longint'(TIMEOUT) > ((longint'(1) << TIMEOUT_WIDTH) - 1) ||
      LONG_CYCLES < 1 || longint'(LONG_CYCLES) > ((longint'(1) << LONG_WIDTH) - 1) ||
      REPEAT_CYCLES < 1) begin : g_bad_cfg
    $error("key_event_debounce: counter parameters out of range");
  end

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;
  logic [WIDTH-1:0] key;

  // Synchronizer stages: reset loads the idle level so a key held through
  // reset is debounced from scratch once reset is released.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_p0 <= IDLE_RAW;
      sync_p1 <= IDLE_RAW;
    end else begin
      sync_p0 <= data_in;
      sync_p1 <= sync_p0;
    end
  end

  assign key = ACTIVE_LOW ? ~sync_p1 : sync_p1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    key_event_channel #(
      .TIMEOUT       (TIMEOUT),
      .TIMEOUT_WIDTH (TIMEOUT_WIDTH),
      .LONG_CYCLES   (LONG_CYCLES),
      .LONG_WIDTH    (LONG_WIDTH),
      .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_chan (
      .clk           (clk),
      .reset_n       (reset_n),
      .key           (key[i]),
      .level         (level[i]),
      .press         (press[i]),
      .release_pulse (release_pulse[i]),
      .long_press    (long_press[i])
    );
  end

endmodule

// File: tb/tb_key_event_debounce.sv
module tb_key_event_debounce;

  localparam int TO = 4;
  localparam int LC = 20;
  localparam int RC = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [1:0] data_in;
  logic [1:0] level, press, release_pulse, long_press;
  logic [0:0] data_hi, level_hi, press_hi, release_hi, long_hi;

  int total = 0;
  int bad   = 0;

  key_event_debounce #(
    .WIDTH(2), .POLARITY("LOW"), .TIMEOUT(TO), .TIMEOUT_WIDTH(16),
    .LONG_CYCLES(LC), .LONG_WIDTH(26), .REPEAT_CYCLES(RC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .level(level),
    .press(press), .release_pulse(release_pulse), .long_press(long_press)
  );

  key_event_debounce #(
    .WIDTH(1), .POLARITY("HIGH"), .TIMEOUT(TO), .TIMEOUT_WIDTH(16),
    .LONG_CYCLES(LC), .LONG_WIDTH(26), .REPEAT_CYCLES(RC)
  ) dut_hi (
    .clk(clk), .reset_n(reset_n), .data_in(data_hi), .level(level_hi),
    .press(press_hi), .release_pulse(release_hi), .long_press(long_hi)
  );

  // Reference model: the key is seen two samples late; the debounced level
  // flips once the seen key disagrees with it for TO consecutive cycles.
  // The hold time counts cycles since the press while the level stays high.
  logic [1:0] m_s1, m_s2;
  int         m_run[2], m_hold[2], m_rep[2];
  logic [1:0] m_level, m_press, m_rel, m_long;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_s1 = 2'b11; m_s2 = 2'b11;
      m_level = '0; m_press = '0; m_rel = '0; m_long = '0;
      for (int c = 0; c < 2; c++) begin
        m_run[c] = 0; m_hold[c] = 0; m_rep[c] = 0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        logic n;
        logic steady_on;
        int   hold_before;
        n = ~m_s2[c];
        m_press[c] = 1'b0; m_rel[c] = 1'b0; m_long[c] = 1'b0;
        steady_on   = m_level[c] && (m_run[c] == 0);
        hold_before = m_hold[c];
        if (n != m_level[c]) m_run[c]++; else m_run[c] = 0;
        if (m_run[c] == TO) begin
          m_run[c]  = 0;
          m_hold[c] = 0;
          if (!m_level[c]) begin m_level[c] = 1'b1; m_press[c] = 1'b1; end
          else begin m_level[c] = 1'b0; m_rel[c] = 1'b1; end
        end else if (m_level[c] && m_hold[c] < LC) begin
          m_hold[c]++;
          if (m_hold[c] == LC) m_long[c] = 1'b1;
        end
`ifdef KEY_AUTOREPEAT_EN
        if (steady_on && n && hold_before == LC) begin
          m_rep[c]++;
          if (m_rep[c] == RC) begin m_rep[c] = 0; m_press[c] = 1'b1; end
        end else begin
          m_rep[c] = 0;
        end
`else
        m_rep[c] = 0;
        if (steady_on && hold_before < 0) m_rep[c] = 1;
`endif
      end
      m_s2 = m_s1;
      m_s1 = data_in;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if ({level, press, release_pulse, long_press} !== 8'h00) begin
        bad++;
        $display("FAIL reset_outputs got %b want 0", {level, press, release_pulse, long_press});
      end
      total++;
      if ({level_hi, press_hi, release_hi, long_hi} !== 4'h0) begin
        bad++;
        $display("FAIL reset_outputs_hi got %b want 0", {level_hi, press_hi, release_hi, long_hi});
      end
    end
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      total++;
      if ({level, press, level_hi, press_hi} !== 6'b0) begin
        bad++;
        $display("FAIL idle_after_reset got %b want 0", {level, press, level_hi, press_hi});
      end
    end
  endtask

  task automatic test_clean_press();
    data_in[0] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      total++;
      if (press[0] !== (k == 6)) begin
        bad++; $display("FAIL clean_press press cyc %0d got %b want %b", k, press[0], (k == 6));
      end
      total++;
      if (level[0] !== (k >= 6)) begin
        bad++; $display("FAIL clean_press level cyc %0d got %b want %b", k, level[0], (k >= 6));
      end
    end
    data_in[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      total++;
      if (release_pulse[0] !== (k == 6)) begin
        bad++; $display("FAIL clean_release release cyc %0d got %b want %b", k, release_pulse[0], (k == 6));
      end
      total++;
      if (level[0] !== (k < 6)) begin
        bad++; $display("FAIL clean_release level cyc %0d got %b want %b", k, level[0], (k < 6));
      end
    end
  endtask

  task automatic test_glitch();
    data_in[0] = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      total++;
      if ({level[0], press[0], release_pulse[0]} !== 3'b000) begin
        bad++; $display("FAIL glitch cyc %0d got %b want 000", k, {level[0], press[0], release_pulse[0]});
      end
      if (k == 2) data_in[0] = 1'b1;
    end
  endtask

  task automatic test_long_hold();
    int press_at[$];
    int long_at[$];
    int rel_at;
    int exp_press[$];
    rel_at = -1;
`ifdef KEY_AUTOREPEAT_EN
    exp_press = '{6, 34, 42};
`else
    exp_press = '{6};
`endif
    data_in[0] = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (press[0]) press_at.push_back(k);
      if (long_press[0]) long_at.push_back(k);
      if (release_pulse[0]) rel_at = k;
      if (k == 46) data_in[0] = 1'b1;
    end
    total++;
    if (long_at.size() != 1) begin
      bad++; $display("FAIL long_hold long_count got %0d want 1", long_at.size());
    end else begin
      total++;
      if (long_at[0] != 26) begin
        bad++; $display("FAIL long_hold long_cycle got %0d want 26", long_at[0]);
      end
    end
    total++;
    if (press_at.size() != exp_press.size()) begin
      bad++; $display("FAIL long_hold press_count got %0d want %0d", press_at.size(), exp_press.size());
    end else begin
      foreach (exp_press[i]) begin
        total++;
        if (press_at[i] != exp_press[i]) begin
          bad++; $display("FAIL long_hold press_cycle[%0d] got %0d want %0d", i, press_at[i], exp_press[i]);
        end
      end
    end
    total++;
    if (rel_at != 52) begin
      bad++; $display("FAIL long_hold release_cycle got %0d want 52", rel_at);
    end
  endtask

  task automatic test_simul_release();
    data_in = 2'b00;
    settle(10);
    total++;
    if (level !== 2'b11) begin
      bad++; $display("FAIL simul_both_pressed level got %b want 11", level);
    end
    data_in = 2'b11;
    for (int k = 1; k <= 10; k++) begin
      tick();
      total++;
      if (release_pulse !== ((k == 6) ? 2'b11 : 2'b00)) begin
        bad++; $display("FAIL simul_release cyc %0d got %b want %b", k, release_pulse, (k == 6) ? 2'b11 : 2'b00);
      end
      total++;
      if (level !== ((k < 6) ? 2'b11 : 2'b00)) begin
        bad++; $display("FAIL simul_release level cyc %0d got %b want %b", k, level, (k < 6) ? 2'b11 : 2'b00);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    data_in[0] = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 17) begin
        total++;
        if ({level, press, release_pulse, long_press} !== 8'h00) begin
          bad++; $display("FAIL reset_mid_hold outputs got %b want 0", {level, press, release_pulse, long_press});
        end
      end
      total++;
      if (long_press[0] !== 1'b0) begin
        bad++; $display("FAIL reset_mid_hold long cyc %0d got %b want 0", k, long_press[0]);
      end
      total++;
      if (press[0] !== (k == 6 || k == 23)) begin
        bad++; $display("FAIL reset_mid_hold press cyc %0d got %b want %b", k, press[0], (k == 6 || k == 23));
      end
      total++;
      if (level[0] !== ((k >= 6 && k < 17) || k >= 23)) begin
        bad++; $display("FAIL reset_mid_hold level cyc %0d got %b", k, level[0]);
      end
      if (k == 16) reset_n = 1'b0;
      if (k == 17) reset_n = 1'b1;
    end
    data_in = 2'b11;
    settle(15);
  endtask

  task automatic test_random();
    logic [1:0] prev_p, prev_r, prev_l;
    prev_p = '0; prev_r = '0; prev_l = '0;
    for (int i = 0; i < 3000; i++) begin
      int rate;
      tick();
      total++;
      if ({level, press, release_pulse, long_press} !== {m_level, m_press, m_rel, m_long}) begin
        bad++;
        $display("FAIL random cyc %0d lvl/prs/rel/lng got %b want %b", i,
                 {level, press, release_pulse, long_press}, {m_level, m_press, m_rel, m_long});
      end
      total++;
      if (((press & prev_p) | (release_pulse & prev_r) | (long_press & prev_l)) !== 2'b00) begin
        bad++; $display("FAIL random_pulse_width cyc %0d got two-cycle pulse, want single", i);
      end
      prev_p = press; prev_r = release_pulse; prev_l = long_press;
      rate = ((i / 200) % 2 == 0) ? 3 : 40;
      for (int b = 0; b < 2; b++)
        if ($urandom_range(0, rate - 1) == 0) data_in[b] = ~data_in[b];
      reset_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
    end
    reset_n = 1'b1;
    data_in = 2'b11;
    settle(20);
  endtask

  task automatic test_polarity_high();
    data_hi = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      total++;
      if (press_hi[0] !== (k == 6)) begin
        bad++; $display("FAIL polarity_high press cyc %0d got %b want %b", k, press_hi[0], (k == 6));
      end
      total++;
      if (level_hi[0] !== (k >= 6)) begin
        bad++; $display("FAIL polarity_high level cyc %0d got %b want %b", k, level_hi[0], (k >= 6));
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    data_in = 2'b11;
    data_hi = 1'b0;
    tick();
    test_reset();
    test_clean_press();
    test_glitch();
    settle(10);
    test_long_hold();
    settle(10);
    test_simul_release();
    settle(5);
    test_reset_mid_hold();
    test_random();
    test_polarity_high();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
